// File: rtl/tile_locator_pipe.sv
// Two-stage pipelined tile locator. It maps a screen pixel onto a COLS x ROWS product grid,
// produces the image ROM address and tile ID, and draws a blinking frame around one selected tile.
module tile_locator_pipe #(
    parameter int          CNTR_WIDTH_H       = 10,
    parameter int          CNTR_WIDTH_V       = 10,
    parameter int          ROM_ADDR_BUS_WIDTH = 17,
    parameter int          ID_WIDTH           = 4,
    parameter int          COLS               = 4,
    parameter int          ROWS               = 3,
    parameter int          ORIGIN_X           = 308,
    parameter int          ORIGIN_Y           = 20,
    parameter int          PITCH_X            = 128,
    parameter int          PITCH_Y            = 128,
    parameter int          PIC_W              = 100,
    parameter int          PIC_H              = 100,
    parameter int          BORDER             = 2,
    parameter int          BLINK_FRAMES       = 30,
    parameter logic [23:0] HL_COLOR           = 24'hFFFF00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic [CNTR_WIDTH_H-1:0]       CounterX,
    input  logic [CNTR_WIDTH_V-1:0]       CounterY,
    input  logic                          frame_start,
    input  logic [ID_WIDTH-1:0]           sel_id,
    output logic                          out_valid,
    output logic                          isImage,
    output logic [ID_WIDTH-1:0]           ImageID,
    output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
    output logic [23:0]                   black_white
);

    localparam int XW  = CNTR_WIDTH_H + 1;
    localparam int YW  = CNTR_WIDTH_V + 1;
    localparam int RW  = ROM_ADDR_BUS_WIDTH;
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [ID_WIDTH:0] NUM_TILES = (ID_WIDTH + 1)'(COLS * ROWS);
    localparam logic [FW-1:0]     FCNT_LAST = FW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    typedef enum logic {BLINK_ON, BLINK_OFF} blink_state_t;

    // Tile bounds; compares run one bit wider than the counters so the all-ones value cannot wrap into a tile.
    function automatic logic [XW-1:0] x_bound(input int c, input int offset);
        return XW'(ORIGIN_X + c * PITCH_X + offset);
    endfunction

    function automatic logic [YW-1:0] y_bound(input int r, input int offset);
        return YW'(ORIGIN_Y + r * PITCH_Y + offset);
    endfunction

    blink_state_t              state_q, state_n;
    logic [FW-1:0]             fcnt_q, fcnt_n;
    logic [ID_WIDTH-1:0]       sel_q;
    logic                      sel_valid, blink_on;

    logic [XW-1:0]             x_ext;
    logic [YW-1:0]             y_ext;
    logic [COLS-1:0]           col_exp;
    logic [ROWS-1:0]           row_exp;
    logic                      col_hit, row_hit, exp_hit_n;
    logic [CIW-1:0]            col_n;
    logic [RIW-1:0]            row_n;
    logic [CNTR_WIDTH_H-1:0]   lx_n;
    logic [CNTR_WIDTH_V-1:0]   ly_n;

    logic                      v1_q, hit_q, hl_q;
    logic [CIW-1:0]            col_q;
    logic [RIW-1:0]            row_q;
    logic [CNTR_WIDTH_H-1:0]   lx_q;
    logic [CNTR_WIDTH_V-1:0]   ly_q;
    logic [ID_WIDTH-1:0]       id_c;
    logic [RW-1:0]             addr_c;

    assign sel_valid = {1'b0, sel_q} < NUM_TILES;
    assign blink_on  = (state_q == BLINK_ON);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLINK_ON;
            fcnt_q  <= '0;
            sel_q   <= '1;
        end else begin
            state_q <= state_n;
            fcnt_q  <= fcnt_n;
            if (frame_start)
                sel_q <= sel_id;
        end
    end

    always_comb begin
        state_n = state_q;
        fcnt_n  = fcnt_q;
        if (BLINK_FRAMES == 0) begin
            state_n = BLINK_ON;
        end else if (frame_start) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_n  = '0;
                state_n = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                fcnt_n = fcnt_q + FW'(1);
            end
        end
    end

    // Stage 1 decode. Expanded boxes never overlap, so matching the selected tile's
    // column/row windows avoids dividing sel_q into col/row.
    always_comb begin
        x_ext     = {1'b0, CounterX};
        y_ext     = {1'b0, CounterY};
        col_exp   = '0;
        row_exp   = '0;
        col_hit   = 1'b0;
        row_hit   = 1'b0;
        col_n     = '0;
        row_n     = '0;
        lx_n      = '0;
        ly_n      = '0;
        exp_hit_n = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            col_exp[c] = (x_ext >= x_bound(c, -BORDER)) && (x_ext <= x_bound(c, PIC_W - 1 + BORDER));
            if ((x_ext >= x_bound(c, 0)) && (x_ext <= x_bound(c, PIC_W - 1))) begin
                col_hit = 1'b1;
                col_n   = CIW'(c);
                lx_n    = CNTR_WIDTH_H'(x_ext - x_bound(c, 0));
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            row_exp[r] = (y_ext >= y_bound(r, -BORDER)) && (y_ext <= y_bound(r, PIC_H - 1 + BORDER));
            if ((y_ext >= y_bound(r, 0)) && (y_ext <= y_bound(r, PIC_H - 1))) begin
                row_hit = 1'b1;
                row_n   = RIW'(r);
                ly_n    = CNTR_WIDTH_V'(y_ext - y_bound(r, 0));
            end
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((sel_q == ID_WIDTH'(r * COLS + c)) && col_exp[c] && row_exp[r])
                    exp_hit_n = 1'b1;
    end

    // Highlight gating is captured with the pixel, so a coincident frame_start only affects later pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            hit_q <= 1'b0;
            hl_q  <= 1'b0;
            col_q <= '0;
            row_q <= '0;
            lx_q  <= '0;
            ly_q  <= '0;
        end else begin
            v1_q  <= pix_valid;
            hit_q <= pix_valid && col_hit && row_hit;
            hl_q  <= pix_valid && exp_hit_n && sel_valid && blink_on;
            col_q <= col_n;
            row_q <= row_n;
            lx_q  <= lx_n;
            ly_q  <= ly_n;
        end
    end

    always_comb begin
        id_c   = ID_WIDTH'(row_q) * ID_WIDTH'(COLS) + ID_WIDTH'(col_q);
        addr_c = RW'(id_c) * RW'(PIC_W * PIC_H) + RW'(ly_q) * RW'(PIC_W) + RW'(lx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            isImage     <= 1'b0;
            ImageID     <= '0;
            ROM_Addr    <= '0;
            black_white <= '0;
        end else begin
            out_valid   <= v1_q;
            isImage     <= v1_q && hit_q;
            ImageID     <= (v1_q && hit_q) ? id_c : '0;
            ROM_Addr    <= (v1_q && hit_q) ? addr_c : '0;
            black_white <= (v1_q && hl_q && !hit_q) ? HL_COLOR : 24'h0;
        end
    end

endmodule
